// File: rtl/uart_tx_serializer_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer_pkg
//   Shared UART definitions: FSM state encodings (3-bit constants so the RX
//   side and older code can use the same numbering), the idle line level and
//   the legal ranges for the frame-format parameters.
// -----------------------------------------------------------------------------
package uart_tx_serializer_pkg;

    // Frame FSM state encodings
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SYNC   = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_PARITY = 3'd4;
    localparam logic [2:0] ST_STOP   = 3'd5;

    // Level of an idle / stop-bit UART line
    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Legal frame-format ranges
    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 8;
    localparam int STOP_BITS_MIN = 1;
    localparam int STOP_BITS_MAX = 2;

endpackage

// File: rtl/uart_tx_shreg.sv
// -----------------------------------------------------------------------------
// uart_tx_shreg
//   Load/shift-right register for the UART transmitter payload.
//   Ports:
//     clk        in   system clock
//     rst        in   synchronous active-high reset (clears the register)
//     load_i     in   load data_i (has priority over shift_i)
//     shift_i    in   shift right by one, zero fill from the top
//     data_i     in   WIDTH-bit parallel load value
//     lsb_next_o out  bit 0 of the value the register takes on the next edge
//   The look-ahead LSB lets the parent register its serial output so that it
//   shows the new bit in the very cycle the shift lands.
// -----------------------------------------------------------------------------
module uart_tx_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             lsb_next_o
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [WIDTH-1:0] shifted;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == WIDTH - 1) begin : g_top
                assign shifted[gi] = 1'b0;
            end else begin : g_mid
                assign shifted[gi] = shreg_q[gi+1];
            end
        end
    endgenerate

    always_comb begin
        shreg_d = shreg_q;
        if (load_i) begin
            shreg_d = data_i;
        end else if (shift_i) begin
            shreg_d = shifted;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign lsb_next_o = shreg_d[0];

endmodule

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//   UART transmit stage. Accepts a word on a valid/ready handshake and sends it
//   LSB-first as: start(0), DATA_BITS data bits, optional parity, STOP_BITS
//   stop bits(1). Each bit lasts one period of the external baud strobe.
//   Build option: define UART_TX_PARITY_EN to insert a parity bit
//   (XOR of the data, inverted when PARITY_ODD=1). Undefined: no parity.
//   Ports:
//     clk       in   system clock
//     rst       in   synchronous active-high reset, aborts any frame
//     tick      in   one-cycle baud strobe per bit period
//     tx_data   in   word to send, captured on handshake
//     tx_valid  in   tx_data valid
//     tx_ready  out  high only while idle
//     tx        out  registered serial line, idle high
//     busy      out  frame in progress
//     tx_done   out  one-cycle pulse on the tick that ends the last stop bit
// -----------------------------------------------------------------------------
module uart_tx_serializer
    import uart_tx_serializer_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int CNT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             stop_cnt_q, stop_cnt_d;
    logic             tx_q, tx_d;
    logic             accept;
    logic             shift;
    logic             lsb_next;

    assign accept = tx_valid && (state_q == ST_IDLE);
    assign shift  = (state_q == ST_DATA) && tick;

    uart_tx_shreg #(
        .WIDTH(DATA_BITS)
    ) u_shreg (
        .clk       (clk),
        .rst       (rst),
        .load_i    (accept),
        .shift_i   (shift),
        .data_i    (tx_data),
        .lsb_next_o(lsb_next)
    );

`ifdef UART_TX_PARITY_EN
    logic parity_q;

    // Parity is fixed at accept time, so the shift register is free to shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (accept) begin
            parity_q <= (^tx_data) ^ PARITY_ODD;
        end
    end
`else
    // Parity sense has no effect when the parity bit is not generated.
    localparam bit parity_odd_unused = PARITY_ODD;
`endif

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        case (state_q)
            ST_IDLE: begin
                bit_cnt_d  = '0;
                stop_cnt_d = 1'b0;
                // A tick in the accept cycle is ignored: SYNC waits for the
                // next one so the start bit always lasts a full period.
                if (accept) begin
                    state_d = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (tick) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line level is decoded from the next state so tx is a clean register
    // that changes exactly on the edge that samples the tick.
    always_comb begin
        tx_d = UART_IDLE_LEVEL;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = lsb_next;
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_q;
`endif
            default:   tx_d = UART_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= UART_IDLE_LEVEL;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
        end
    end

    assign tx       = tx_q;
    assign tx_ready = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    // Pulses on the tick that closes the last stop bit; tx_ready follows next cycle.
    assign tx_done  = (state_q == ST_STOP) && tick && (stop_cnt_q == STOP_LAST);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_serializer
//   Two instances: A (STOP_BITS=1, even parity sense) and B (STOP_BITS=2, odd
//   parity sense). Baud tick every 4 clks. Expected frames are written out
//   bit by bit in line order (first character = start bit); the parity build
//   (UART_TX_PARITY_EN) uses the second set of literals.
// -----------------------------------------------------------------------------
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       valid_a = 1'b0;
    logic       valid_b = 1'b0;
    logic       ready_a, tx_a, busy_a, done_a;
    logic       ready_b, tx_b, busy_b, done_b;
    logic       sel_b = 1'b0;
    logic       tx_s, ready_s, busy_s, done_s;

    int checks = 0;
    int errors = 0;
    int tick_ph = 0;

    uart_tx_serializer #(
        .DATA_BITS (8),
        .STOP_BITS (1),
        .PARITY_ODD(1'b0)
    ) dut_a (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .tx_data (tx_data),
        .tx_valid(valid_a),
        .tx_ready(ready_a),
        .tx      (tx_a),
        .busy    (busy_a),
        .tx_done (done_a)
    );

    uart_tx_serializer #(
        .DATA_BITS (8),
        .STOP_BITS (2),
        .PARITY_ODD(1'b1)
    ) dut_b (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .tx_data (tx_data),
        .tx_valid(valid_b),
        .tx_ready(ready_b),
        .tx      (tx_b),
        .busy    (busy_b),
        .tx_done (done_b)
    );

    assign tx_s    = sel_b ? tx_b    : tx_a;
    assign ready_s = sel_b ? ready_b : ready_a;
    assign busy_s  = sel_b ? busy_b  : busy_a;
    assign done_s  = sel_b ? done_b  : done_a;

    always #5 clk = ~clk;

    // Tick changes just after the rising edge, so it is stable at the falling
    // edge where the stimulus looks at it.
    always @(posedge clk) begin
        #1;
        tick_ph = (tick_ph + 1) % 4;
        tick = (tick_ph == 0);
    end

    typedef struct packed {
        logic [7:0]  data;
        logic        use_b;
        logic [3:0]  nbits;
        logic [11:0] bits;
    } vec_t;

    vec_t vec [6];

`ifdef UART_TX_PARITY_EN
    localparam int NA = 11;
    localparam int NB = 12;
    localparam logic [11:0] E11 = 12'b01000100001;
    localparam logic [11:0] E22 = 12'b00100010001;
    localparam logic [11:0] E3C = 12'b00011110001;
    localparam logic [11:0] E5A = 12'b001011010111;
`else
    localparam int NA = 10;
    localparam int NB = 11;
    localparam logic [11:0] E11 = 12'b0100010001;
    localparam logic [11:0] E22 = 12'b0010001001;
    localparam logic [11:0] E3C = 12'b0001111001;
    localparam logic [11:0] E5A = 12'b00101101011;
`endif

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Called at a falling edge with the selected instance idle.
    task automatic send(input logic b, input logic [7:0] d);
        sel_b   = b;
        tx_data = d;
        if (b) valid_b = 1'b1;
        else   valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        valid_b = 1'b0;
        check("busy_after_accept", busy_s, 1'b1);
    endtask

    // Waits for the start bit, then checks every bit for exactly 4 clks and
    // that tx_done fires only in the final cycle of the frame.
    task automatic capture(input string name, input logic [11:0] exp,
                           input int nbits, output int lat);
        int   n;
        logic ok;
        logic done_ok;
        n = 0;
        done_ok = 1'b1;
        lat = 0;
        while (tx_s !== 1'b0 && n < 40) begin
            if (done_s !== 1'b0) done_ok = 1'b0;
            n++;
            @(negedge clk);
        end
        lat = n;
        if (tx_s !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL %s start_timeout: tx=%b, required 0 within 40 clks", name, tx_s);
            return;
        end
        for (int k = 0; k < nbits; k++) begin
            ok = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (!(k == 0 && c == 0)) @(negedge clk);
                if (tx_s !== exp[nbits-1-k]) ok = 1'b0;
                if (done_s !== ((k == nbits - 1) && (c == 3))) done_ok = 1'b0;
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL %s bit%0d: tx=%b at end of period, required %b for all 4 clks",
                         name, k, tx_s, exp[nbits-1-k]);
            end
        end
        checks++;
        if (!done_ok) begin
            errors++;
            $display("FAIL %s tx_done: pulse missing or misplaced, required one pulse in last clk",
                     name);
        end
        @(negedge clk);
        check("ready_after_done", ready_s, 1'b1);
        check("tx_idle_after_done", tx_s, 1'b1);
        $display("frame %s: %0d bits checked, start latency %0d clks", name, nbits, lat);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int lat;
        int n;
`ifdef UART_TX_PARITY_EN
        vec[0] = '{8'hA5, 1'b0, 4'd11, 12'b01010010101};
        vec[1] = '{8'h07, 1'b0, 4'd11, 12'b01110000011};
        vec[2] = '{8'h3C, 1'b0, 4'd11, 12'b00011110001};
        vec[3] = '{8'h00, 1'b1, 4'd12, 12'b000000000111};
        vec[4] = '{8'h80, 1'b1, 4'd12, 12'b000000001011};
        vec[5] = '{8'h07, 1'b1, 4'd12, 12'b011100000011};
`else
        vec[0] = '{8'hA5, 1'b0, 4'd10, 12'b0101001011};
        vec[1] = '{8'h07, 1'b0, 4'd10, 12'b0111000001};
        vec[2] = '{8'h3C, 1'b0, 4'd10, 12'b0001111001};
        vec[3] = '{8'h00, 1'b1, 4'd11, 12'b00000000011};
        vec[4] = '{8'h80, 1'b1, 4'd11, 12'b00000000111};
        vec[5] = '{8'h07, 1'b1, 4'd11, 12'b01110000011};
`endif

        // Reset held for 3 clks
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_tx_a", tx_a, 1'b1);
        check("rst_ready_a", ready_a, 1'b1);
        check("rst_busy_a", busy_a, 1'b0);
        check("rst_done_a", done_a, 1'b0);
        check("rst_tx_b", tx_b, 1'b1);
        check("rst_ready_b", ready_b, 1'b1);
        $display("reset: outputs checked");

        // Table-driven single frames
        for (int i = 0; i < 6; i++) begin
            send(vec[i].use_b, vec[i].data);
            capture($sformatf("vec%0d_%02h", i, vec[i].data), vec[i].bits,
                    int'(vec[i].nbits), lat);
            checks++;
            if (lat < 1 || lat > 4) begin
                errors++;
                $display("FAIL vec%0d latency: got %0d clks required 1..4", i, lat);
            end
        end

        // Back-to-back with tx_valid held high; data changes while busy
        sel_b   = 1'b0;
        tx_data = 8'h11;
        valid_a = 1'b1;
        @(negedge clk);
        tx_data = 8'h22;
        check("b2b_busy", busy_a, 1'b1);
        capture("b2b_11", E11, NA, lat);
        @(negedge clk);
        valid_a = 1'b0;
        check("b2b_second_accept", busy_a, 1'b1);
        capture("b2b_22", E22, NA, lat);

        // Reset in the middle of data bit 3 of 0xFF
        send(1'b0, 8'hFF);
        n = 0;
        while (tx_a !== 1'b0 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("rst_mid_start_seen", tx_a, 1'b0);
        repeat (17) @(negedge clk);
        check("rst_mid_busy_before", busy_a, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_tx", tx_a, 1'b1);
        check("rst_mid_busy", busy_a, 1'b0);
        check("rst_mid_ready", ready_a, 1'b1);
        $display("reset mid-frame: state checked");
        send(1'b0, 8'h3C);
        capture("after_rst_3C", E3C, NA, lat);

        // Tick coincident with accept on the 2-stop-bit instance
        n = 0;
        while (tick !== 1'b1 && n < 8) begin
            n++;
            @(negedge clk);
        end
        check("tick_align", tick, 1'b1);
        send(1'b1, 8'h5A);
        capture("tick_at_accept_5A", E5A, NB, lat);
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL tick_at_accept latency: got %0d clks required 4", lat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
